serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits; legal range 1..32.
REQ-002 clk_pin  input  1  system clock; all state updates on rising edge.
REQ-003 rst_pin  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 sub  input  1  operation select: 0 = a+b, 1 = a-b; latched with start.
REQ-006 a  input  WIDTH  operand A; latched with start.
REQ-007 b  input  WIDTH  operand B; latched with start.
REQ-008 sum  output  WIDTH  result, registered, held until next completion.
REQ-009 cout  output  1  carry out of MSB; in subtract mode 1 = no borrow (a >= b unsigned).
REQ-010 ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse marking valid, newly updated sum/cout/ovf.

Function
REQ-013 The block SHALL use one 1-bit full-adder datapath and a carry flip-flop, processing one bit per cycle, LSB first.
REQ-014 The block SHALL implement states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE, start=1 at edge T: latch a; latch b XOR {WIDTH{sub}}; carry <= sub; bit counter <= 0; -> RUN; busy=1 after T.
REQ-016 IDLE, start=0: remain IDLE; all outputs hold.
REQ-017 RUN, each edge: bit i = a[i] ^ b'[i] ^ carry into internal shift register; carry <= majority(a[i], b'[i], carry); counter +1.
REQ-018 RUN, edge with counter = WIDTH-1: load sum from the completed internal result; set cout = final carry and ovf = carry into MSB XOR final carry; -> DONE.
REQ-019 On entry to DONE, done SHALL be 1 and busy 0, exactly WIDTH edges after the start edge T.
REQ-020 DONE, next edge: done <= 0, -> IDLE unconditionally.
REQ-021 Latency: result visible WIDTH cycles after start is sampled; next start accepted no earlier than edge T+WIDTH+2.
REQ-022 start SHALL be ignored in RUN and DONE; changes on a, b, sub after the start edge SHALL NOT affect the result.
REQ-023 sum, cout, ovf SHALL change only on the RUN->DONE edge; intermediate bits SHALL NOT be visible on sum.
REQ-024 Arithmetic is modulo 2^WIDTH; the counter SHALL be ceil(log2(WIDTH+1)) bits and never wrap within an operation.
REQ-025 WIDTH=1 SHALL behave as a registered single-bit full adder/subtractor (1 RUN cycle).

Reset
REQ-026 rst_pin=1 at any edge SHALL force state IDLE and sum=0, cout=0, ovf=0, busy=0, done=0, and clear carry, counter and internal registers.
REQ-027 Reset during RUN SHALL abort the operation with no done pulse; reset has priority over start on the same edge.
REQ-028 After rst_pin falls, start SHALL be accepted on the first edge at which it is sampled high.

Verification (WIDTH=4 unless noted)
REQ-029 a=3, b=5, sub=0, start pulse -> busy 4 cycles; done pulse with sum=8 (1000), cout=0, ovf=1.
REQ-030 a=15, b=1, sub=0 -> sum=0, cout=1, ovf=0; a=5, b=7, sub=1 -> sum=14 (1110), cout=0, ovf=0.
REQ-031 start held high continuously, a/b toggled during RUN -> exactly one done per accepted start (every WIDTH+2 cycles); results match operands latched at each accepting edge.
REQ-032 rst_pin asserted 2 cycles after start -> next cycle all outputs 0, busy=0, no done; a fresh start then completes correctly.
REQ-033 WIDTH=1, all 8 combinations of a, b, sub -> sum/cout match the full-adder (sub: a + ~b + 1) truth table after 1 cycle.
REQ-034 WIDTH=8, randomized 1000 operations vs. reference model -> sum/cout/ovf all match; done count equals accepted starts.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full adder plus a carry flop, LSB first.
// Latency: done pulses WIDTH cycles after start is sampled; next start at T+WIDTH+2.
// Backpressure: none; start is ignored while busy and during the done cycle.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk_pin,
  input  logic             rst_pin,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted for subtraction
  logic [WIDTH-1:0] res_q;    // internal result, filled one bit per cycle
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             bit_d;
  logic             carry_d;
  logic [WIDTH-1:0] res_d;

  // Single full adder on the current LSB of the operand shift registers;
  // the sum bit is written into the result slot selected by the bit counter.
  always_comb begin
    bit_d   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    res_d   = res_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_q == CNT_W'(i)) res_d[i] = bit_d;
    end
  end

  // Control FSM and datapath registers; outputs only move on the RUN->DONE edge.
  always_ff @(posedge clk_pin) begin
    if (rst_pin) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub;           // +1 completes the two's-complement negate
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            sum_q   <= res_d;
            cout_q  <= carry_d;
            ovf_q   <= carry_q ^ carry_d;  // carry into MSB vs carry out of MSB
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at WIDTH 4, 1 and 8 against an arithmetic reference.
// Each operation checks latency, busy/done timing, result hold and final values.
module tb_serial_addsub;

  logic        clk;
  logic        rst;
  logic        start_s [3];
  logic        sub_s   [3];
  logic [31:0] a_s     [3];
  logic [31:0] b_s     [3];
  logic [31:0] sum_s   [3];
  logic        cout_s  [3];
  logic        ovf_s   [3];
  logic        busy_s  [3];
  logic        done_s  [3];

  logic [3:0] sum0;
  logic [0:0] sum1;
  logic [7:0] sum2;

  int n_checks = 0;
  int n_err    = 0;
  int n_ops    [3];
  int n_done   [3];
  logic [31:0] prev_sum  [3];
  logic        prev_cout [3];
  logic        prev_ovf  [3];

  serial_addsub #(.WIDTH(4)) dut_w4 (
    .clk_pin(clk), .rst_pin(rst), .start(start_s[0]), .sub(sub_s[0]),
    .a(a_s[0][3:0]), .b(b_s[0][3:0]), .sum(sum0), .cout(cout_s[0]),
    .ovf(ovf_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  serial_addsub #(.WIDTH(1)) dut_w1 (
    .clk_pin(clk), .rst_pin(rst), .start(start_s[1]), .sub(sub_s[1]),
    .a(a_s[1][0:0]), .b(b_s[1][0:0]), .sum(sum1), .cout(cout_s[1]),
    .ovf(ovf_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  serial_addsub #(.WIDTH(8)) dut_w8 (
    .clk_pin(clk), .rst_pin(rst), .start(start_s[2]), .sub(sub_s[2]),
    .a(a_s[2][7:0]), .b(b_s[2][7:0]), .sum(sum2), .cout(cout_s[2]),
    .ovf(ovf_s[2]), .busy(busy_s[2]), .done(done_s[2]));

  assign sum_s[0] = {28'd0, sum0};
  assign sum_s[1] = {31'd0, sum1};
  assign sum_s[2] = {24'd0, sum2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) if (done_s[k]) n_done[k]++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int wof(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 8;
  endfunction

  // Plain integer arithmetic: unsigned result/carry, signed range for overflow.
  function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input logic sv, output logic [31:0] s,
                                output logic c, output logic o);
    longint m, ua, ub, sa, sb, r, sr;
    m  = longint'(1) << w;
    ua = longint'(av) & (m - 1);
    ub = longint'(bv) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (sv) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      c  = (r >= m);
      sr = sa + sb;
    end
    s = 32'(r & (m - 1));
    o = (sr > m / 2 - 1) || (sr < -(m / 2));
  endfunction

  // Called at a negedge with instance k idle; returns at the negedge after DONE.
  task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input bit keep_start);
    int w;
    int cyc;
    logic [31:0] es;
    logic ec, eo;
    w = wof(k);
    model(w, av, bv, sv, es, ec, eo);
    a_s[k] = av; b_s[k] = bv; sub_s[k] = sv; start_s[k] = 1'b1;
    @(negedge clk);
    if (!keep_start) start_s[k] = 1'b0;
    a_s[k] = $urandom; b_s[k] = $urandom; sub_s[k] = 1'($urandom);
    chk("busy_after_start", {31'd0, busy_s[k]}, 32'd1);
    cyc = 0;
    while (!done_s[k] && cyc < w + 4) begin
      chk("sum_hold_run", sum_s[k], prev_sum[k]);
      chk("cout_hold_run", {31'd0, cout_s[k]}, {31'd0, prev_cout[k]});
      @(negedge clk);
      cyc++;
      a_s[k] = $urandom; b_s[k] = $urandom;
    end
    chk("done_latency", cyc, w);
    chk("sum", sum_s[k], es);
    chk("cout", {31'd0, cout_s[k]}, {31'd0, ec});
    chk("ovf", {31'd0, ovf_s[k]}, {31'd0, eo});
    chk("busy_at_done", {31'd0, busy_s[k]}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done_s[k]}, 32'd0);
    chk("sum_after_done", sum_s[k], es);
    prev_sum[k] = es; prev_cout[k] = ec; prev_ovf[k] = eo;
    n_ops[k]++;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; sub_s[k] = 1'b0; a_s[k] = '0; b_s[k] = '0;
      n_ops[k] = 0; n_done[k] = 0;
      prev_sum[k] = '0; prev_cout[k] = 1'b0; prev_ovf[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_sum", sum_s[k], 32'd0);
      chk("rst_flags", {28'd0, cout_s[k], ovf_s[k], busy_s[k], done_s[k]}, 32'd0);
    end
    rst = 1'b0;

    // Directed WIDTH=4 cases
    run_op(0, 32'd3, 32'd5, 1'b0, 1'b0);
    run_op(0, 32'd15, 32'd1, 1'b0, 1'b0);
    run_op(0, 32'd5, 32'd7, 1'b1, 1'b0);
    run_op(0, 32'd0, 32'd8, 1'b1, 1'b0);
    run_op(0, 32'd8, 32'd8, 1'b0, 1'b0);

    // Idle with start low: outputs hold regardless of operand activity
    for (int i = 0; i < 3; i++) begin
      a_s[0] = $urandom; b_s[0] = $urandom; sub_s[0] = 1'($urandom);
      @(negedge clk);
      chk("idle_hold_sum", sum_s[0], prev_sum[0]);
      chk("idle_busy", {31'd0, busy_s[0]}, 32'd0);
    end

    // start held high across back-to-back operations
    for (int i = 0; i < 4; i++)
      run_op(0, $urandom, $urandom, 1'($urandom), 1'b1);
    start_s[0] = 1'b0;

    // Reset two cycles into a run, with start held high during reset
    a_s[0] = 32'd9; b_s[0] = 32'd4; sub_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1; start_s[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrun_rst_sum", sum_s[0], 32'd0);
      chk("midrun_rst_flags", {28'd0, cout_s[0], ovf_s[0], busy_s[0], done_s[0]}, 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      prev_sum[k] = '0; prev_cout[k] = 1'b0; prev_ovf[k] = 1'b0;
    end
    rst = 1'b0;
    run_op(0, 32'd9, 32'd4, 1'b0, 1'b0);

    // WIDTH=1 full truth table
    for (int i = 0; i < 8; i++)
      run_op(1, 32'(i & 1), 32'((i >> 1) & 1), 1'((i >> 2) & 1), 1'b0);

    // WIDTH=8 randomized operations, sometimes leaving start high
    for (int i = 0; i < 1000; i++)
      run_op(2, $urandom, $urandom, 1'($urandom), 1'($urandom));
    start_s[2] = 1'b0;
    repeat (12) @(negedge clk);

    for (int k = 0; k < 3; k++)
      chk("done_count", 32'(n_done[k]), 32'(n_ops[k]));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
